// File: rtl/scan_chain_sequencer.sv
// Scan chain sequencer: loads one pattern into a scan chain, pulses capture,
// unloads the response and compares it against an expected word under a mask.
module scan_chain_sequencer #(
  parameter int CHAIN_LEN = 16,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [CHAIN_LEN-1:0] PAT,
  input  logic [CHAIN_LEN-1:0] EXP,
  input  logic [CHAIN_LEN-1:0] MASK,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 PASS,
  output logic [CHAIN_LEN-1:0] RESP
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CAPTURE,
    S_UNLOAD,
    S_REPORT
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

  state_t                 r_state, w_state_next;
  logic [CNT_W-1:0]       r_cnt, w_cnt_next;
  logic [CHAIN_LEN-1:0]   r_shift, w_shift_next;
  logic [CHAIN_LEN-1:0]   r_exp, w_exp_next;
  logic [CHAIN_LEN-1:0]   r_mask, w_mask_next;
  logic [CHAIN_LEN-1:0]   r_resp, w_resp_next;
  logic                   r_pass, w_pass_next;
  logic                   r_se, w_se_next;
  logic                   r_si, w_si_next;
  logic                   r_done, w_done_next;
  logic                   r_busy, w_busy_next;
  logic [CHAIN_LEN-1:0]   w_resp_sampled;
  logic                   w_pass_calc;

  // Response word with the current unload bit (index = counter) taken from SO.
  genvar gi;
  generate
    for (gi = 0; gi < CHAIN_LEN; gi++) begin : g_resp_bit
      assign w_resp_sampled[gi] = (r_cnt == CNT_W'(gi)) ? SO : r_resp[gi];
    end
  endgenerate

  assign w_pass_calc = &((w_resp_sampled ~^ r_exp) | r_mask);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_shift_next = r_shift;
    w_exp_next   = r_exp;
    w_mask_next  = r_mask;
    w_resp_next  = r_resp;
    w_pass_next  = r_pass;
    w_se_next    = 1'b0;
    w_si_next    = 1'b0;
    w_done_next  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (START && !ABORT) begin
          w_state_next = S_LOAD;
          w_cnt_next   = LAST_CNT;
          w_shift_next = {PAT[CHAIN_LEN-2:0], 1'b0};
          w_exp_next   = EXP;
          w_mask_next  = MASK;
          w_resp_next  = '0;
          w_pass_next  = 1'b0;
          w_se_next    = 1'b1;
          w_si_next    = PAT[CHAIN_LEN-1];
        end
      end
      S_LOAD: begin
        if (r_cnt == '0) begin
          w_state_next = S_CAPTURE;
        end else begin
          w_cnt_next   = r_cnt - 1'b1;
          w_se_next    = 1'b1;
          w_si_next    = r_shift[CHAIN_LEN-1];
          w_shift_next = {r_shift[CHAIN_LEN-2:0], 1'b0};
        end
      end
      S_CAPTURE: begin
        w_state_next = S_UNLOAD;
        w_cnt_next   = LAST_CNT;
        w_se_next    = 1'b1;
      end
      S_UNLOAD: begin
        w_resp_next = w_resp_sampled;
        if (r_cnt == '0) begin
          w_state_next = S_REPORT;
          w_done_next  = 1'b1;
          w_pass_next  = w_pass_calc;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
          w_se_next  = 1'b1;
        end
      end
      S_REPORT: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Abort drops the run where it stands; partial response bits are kept.
    if (ABORT && r_state != S_IDLE) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
      w_resp_next  = r_resp;
      w_pass_next  = r_pass;
      w_se_next    = 1'b0;
      w_si_next    = 1'b0;
      w_done_next  = 1'b0;
    end

    w_busy_next = (w_state_next != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_exp   <= '0;
      r_mask  <= '0;
      r_resp  <= '0;
      r_pass  <= 1'b0;
      r_se    <= 1'b0;
      r_si    <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_shift <= w_shift_next;
      r_exp   <= w_exp_next;
      r_mask  <= w_mask_next;
      r_resp  <= w_resp_next;
      r_pass  <= w_pass_next;
      r_se    <= w_se_next;
      r_si    <= w_si_next;
      r_done  <= w_done_next;
      r_busy  <= w_busy_next;
    end
  end

  assign SE   = r_se;
  assign SI   = r_si;
  assign BUSY = r_busy;
  assign DONE = r_done;
  assign PASS = r_pass;
  assign RESP = r_resp;

endmodule

// File: tb/tb_scan_chain_sequencer.sv
// Directed bench for scan_chain_sequencer with behavioural scan chains of
// length 4 (D = ~Q), 2 (D = ~Q) and 16 (D = Q).
module tb_scan_chain_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // ---- 4-cell instance ----
  logic       start4, abort4, so4, se4, si4, busy4, done4, pass4;
  logic [3:0] pat4, exp4, mask4, resp4, ch4;

  scan_chain_sequencer #(.CHAIN_LEN(4)) u_dut4 (
    .CLK(clk), .RST(rst), .START(start4), .ABORT(abort4),
    .PAT(pat4), .EXP(exp4), .MASK(mask4), .SO(so4),
    .SE(se4), .SI(si4), .BUSY(busy4), .DONE(done4), .PASS(pass4), .RESP(resp4)
  );

  always @(posedge clk) begin
    if (se4) ch4 <= {ch4[2:0], si4};
    else     ch4 <= ~ch4;
  end
  assign so4 = ch4[3];

  // ---- 2-cell instance ----
  logic       start2, abort2, so2, se2, si2, busy2, done2, pass2;
  logic [1:0] pat2, exp2, mask2, resp2, ch2;

  scan_chain_sequencer #(.CHAIN_LEN(2)) u_dut2 (
    .CLK(clk), .RST(rst), .START(start2), .ABORT(abort2),
    .PAT(pat2), .EXP(exp2), .MASK(mask2), .SO(so2),
    .SE(se2), .SI(si2), .BUSY(busy2), .DONE(done2), .PASS(pass2), .RESP(resp2)
  );

  always @(posedge clk) begin
    if (se2) ch2 <= {ch2[0], si2};
    else     ch2 <= ~ch2;
  end
  assign so2 = ch2[1];

  // ---- 16-cell instance ----
  logic        start16, abort16, so16, se16, si16, busy16, done16, pass16;
  logic [15:0] pat16, exp16, mask16, resp16, ch16;

  scan_chain_sequencer #(.CHAIN_LEN(16)) u_dut16 (
    .CLK(clk), .RST(rst), .START(start16), .ABORT(abort16),
    .PAT(pat16), .EXP(exp16), .MASK(mask16), .SO(so16),
    .SE(se16), .SI(si16), .BUSY(busy16), .DONE(done16), .PASS(pass16), .RESP(resp16)
  );

  always @(posedge clk) begin
    if (se16) ch16 <= {ch16[14:0], si16};
    else      ch16 <= ch16;
  end
  assign so16 = ch16[15];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full run on the 4-cell chain with cycle-exact checks of SE/SI/BUSY/DONE.
  task automatic run4(input logic [3:0] pat, input logic [3:0] ex, input logic [3:0] mk,
                      input logic [3:0] want_resp, input logic want_pass);
    pat4 = pat; exp4 = ex; mask4 = mk; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if (c <= 4) check($sformatf("si_c%0d", c), 32'(si4), 32'(pat[4-c]));
      check($sformatf("se_c%0d", c), 32'(se4), 32'((c <= 4) || (c >= 6 && c <= 9)));
      check($sformatf("busy_c%0d", c), 32'(busy4), 32'(c <= 10));
      check($sformatf("done_c%0d", c), 32'(done4), 32'(c == 10));
      if (c == 10) begin
        check("resp4", 32'(resp4), 32'(want_resp));
        check("pass4", 32'(pass4), 32'(want_pass));
        $display("run4 pat=%b exp=%b mask=%b resp=%b pass=%b", pat, ex, mk, resp4, pass4);
      end
      tick();
    end
  endtask

  int done_cnt;
  int c2, c16;

  initial begin
    rst = 1'b1;
    start4 = 0; abort4 = 0; pat4 = 0; exp4 = 0; mask4 = 0;
    start2 = 0; abort2 = 0; pat2 = 0; exp2 = 0; mask2 = 0;
    start16 = 0; abort16 = 0; pat16 = 0; exp16 = 0; mask16 = 0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_se", 32'(se4), 0);
    check("rst_si", 32'(si4), 0);
    check("rst_busy", 32'(busy4), 0);
    check("rst_done", 32'(done4), 0);
    check("rst_pass", 32'(pass4), 0);
    check("rst_resp", 32'(resp4), 0);
    $display("reset checked");

    // Basic run, failing compare, then masked rerun.
    run4(4'b1010, 4'b0101, 4'b0000, 4'b0101, 1'b1);
    run4(4'b1010, 4'b0111, 4'b0000, 4'b0101, 1'b0);
    run4(4'b1010, 4'b0111, 4'b0010, 4'b0101, 1'b1);

    // START held high: back-to-back runs every 11 cycles; PAT changes while busy are ignored.
    done_cnt = 0;
    pat4 = 4'b1010; exp4 = 4'b0101; mask4 = 4'b0000; start4 = 1'b1;
    tick();
    for (int t = 1; t <= 33; t++) begin
      if (t == 2) pat4 = 4'b1111;
      if (done4) begin
        done_cnt++;
        check($sformatf("hold_done_t%0d", t), 32'(t == 10 || t == 21 || t == 32), 1);
      end
      if (t == 10) check("hold_resp_r1", 32'(resp4), 32'h5);
      if (t == 21) check("hold_resp_r2", 32'(resp4), 32'h0);
      if (t == 11 || t == 22) check($sformatf("hold_idle_t%0d", t), 32'(busy4), 0);
      if (t == 12) check("hold_busy_r2", 32'(busy4), 1);
      if (t == 33) start4 = 1'b0;
      tick();
    end
    check("hold_done_count", 32'(done_cnt), 3);
    check("hold_stop", 32'(busy4), 0);
    $display("start-held runs dones=%0d", done_cnt);

    // START and ABORT together in IDLE: START is ignored.
    start4 = 1'b1; abort4 = 1'b1;
    tick();
    start4 = 1'b0; abort4 = 1'b0;
    check("start_abort_idle", 32'(busy4), 0);

    // Previous-run PASS=1 then ABORT in load cycle 2.
    run4(4'b1010, 4'b0101, 4'b0000, 4'b0101, 1'b1);
    pat4 = 4'b1010; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    abort4 = 1'b1;
    tick();
    abort4 = 1'b0;
    check("abort_se", 32'(se4), 0);
    check("abort_si", 32'(si4), 0);
    check("abort_busy", 32'(busy4), 0);
    check("abort_pass", 32'(pass4), 0);
    done_cnt = 0;
    for (int t = 0; t < 12; t++) begin
      if (done4) done_cnt++;
      tick();
    end
    check("abort_no_done", 32'(done_cnt), 0);
    $display("abort run: dones=%0d busy=%b", done_cnt, busy4);

    // RST in unload cycle 1 (cycle 6), then START two cycles later.
    pat4 = 4'b1010; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int t = 1; t < 6; t++) tick();
    check("pre_rst_se", 32'(se4), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_se", 32'(se4), 0);
    check("mrst_si", 32'(si4), 0);
    check("mrst_busy", 32'(busy4), 0);
    check("mrst_done", 32'(done4), 0);
    check("mrst_pass", 32'(pass4), 0);
    check("mrst_resp", 32'(resp4), 0);
    $display("mid-unload reset checked");
    tick();
    run4(4'b1100, 4'b0011, 4'b0000, 4'b0011, 1'b1);

    // Length-2 and length-16 chains run together.
    pat2 = 2'b10; exp2 = 2'b01; mask2 = 2'b00; start2 = 1'b1;
    pat16 = 16'hA5C3; exp16 = 16'hA5C3; mask16 = 16'h0000; start16 = 1'b1;
    tick();
    start2 = 1'b0; start16 = 1'b0;
    c2 = -1; c16 = -1;
    for (int t = 1; t <= 40; t++) begin
      if (t == 1) check("si2_c1", 32'(si2), 1);
      if (t == 2) check("si2_c2", 32'(si2), 0);
      if (done2) begin
        c2 = t;
        check("resp2", 32'(resp2), 32'h1);
        check("pass2", 32'(pass2), 1);
      end
      if (done16) begin
        c16 = t;
        check("resp16", 32'(resp16), 32'hA5C3);
        check("pass16", 32'(pass16), 1);
      end
      tick();
    end
    check("done2_cycle", 32'(c2), 6);
    check("done16_cycle", 32'(c16), 34);
    check("busy2_end", 32'(busy2), 0);
    check("busy16_end", 32'(busy16), 0);
    $display("run2 resp=%b pass=%b; run16 resp=%h pass=%b", resp2, pass2, resp16, pass16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
